// File: rtl/adcv_pkg.sv
// Shared widths, pairing-FSM encoding and status bit positions for the
// ramp-compare ADC pair accumulator.
package adcv_pkg;

    // Sample carries coarse*2^FINE_BITS plus up to 2*(2^FINE_BITS-1) of fine
    // correction, hence one extra bit above coarse+fine.
    function automatic int sample_w(input int coarse_bits, input int fine_bits);
        return coarse_bits + fine_bits + 1;
    endfunction

    // Accumulator holds up to 2^avg_log2_max samples without wrapping.
    function automatic int acc_w(input int coarse_bits, input int fine_bits,
                                 input int avg_log2_max);
        return sample_w(coarse_bits, fine_bits) + avg_log2_max;
    endfunction

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_WAIT_FALL = 1'b1
    } pair_state_t;

    localparam int STAT_STRAY_FALL = 0;
    localparam int STAT_OVERFLOW   = 1;
    localparam int STAT_TIMEOUT    = 2;

endpackage

// File: rtl/adcv_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head word is presented
// combinationally from storage; an empty FIFO presents zero.
module adcv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = empty ? '0 : mem[rd_ptr_q];

    // A pop on an empty FIFO is ignored; a full FIFO accepts a push only if
    // the same cycle also pops.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q + LW'(do_push) - LW'(do_pop);
    end

    // Storage write; contents need no reset because empty gates the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/adcv_pair_accum.sv
// Rise/fall TDC pairing, coarse range extension, power-of-two averaging and
// result buffering for the ramp-compare ADC back end.
module adcv_pair_accum
    import adcv_pkg::*;
#(
    parameter int FINE_BITS    = 6,
    parameter int COARSE_BITS  = 4,
    parameter int OFFSET       = 63,
    parameter int AVG_LOG2_MAX = 4,
    parameter int FIFO_DEPTH   = 8,
    localparam int SAMPLE_W    = sample_w(COARSE_BITS, FINE_BITS),
    localparam int ACC_W       = acc_w(COARSE_BITS, FINE_BITS, AVG_LOG2_MAX),
    localparam int LEVEL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           avg_log2,
    input  logic                 rise_valid,
    input  logic [FINE_BITS-1:0] rise_fine,
    input  logic                 fall_valid,
    input  logic [FINE_BITS-1:0] fall_fine,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SAMPLE_W-1:0]  out_data,
    output logic [LEVEL_W-1:0]   fifo_level,
    input  logic                 clear_status,
    output logic [2:0]           status
);

    localparam int CNT_W = AVG_LOG2_MAX + 1;
    localparam logic [COARSE_BITS-1:0] COARSE_MAX = '1;

    pair_state_t          state_q, state_d;
    logic [FINE_BITS-1:0] rise_q, rise_d;
    logic [COARSE_BITS-1:0] coarse_q, coarse_d;
    logic                 pair_done;
    logic                 timeout_ev;
    logic                 stray_ev;
    logic                 overflow_ev;

    logic [SAMPLE_W-1:0]  sample_q, sample_d;
    logic                 sample_vld_q, sample_vld_d;

    logic [ACC_W-1:0]     acc_q, acc_d, acc_sum;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [2:0]           n_q, n_d, n_eff, avg_clamped;
    logic [SAMPLE_W-1:0]  result_q, result_d;
    logic                 result_vld_q, result_vld_d;

    logic [2:0]           status_q, status_d;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Pairing FSM. coarse_q counts cycles since the rise edge, so during the
    // fall cycle it already equals fall_cycle - rise_cycle.
    always_comb begin
        state_d    = state_q;
        rise_d     = rise_q;
        coarse_d   = coarse_q;
        pair_done  = 1'b0;
        timeout_ev = 1'b0;
        stray_ev   = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise_valid) begin
                        rise_d   = rise_fine;
                        coarse_d = COARSE_BITS'(1);
                        state_d  = ST_WAIT_FALL;
                    end else if (fall_valid) begin
                        stray_ev = 1'b1;
                    end
                end
                ST_WAIT_FALL: begin
                    coarse_d = coarse_q + 1'b1;
                    if (fall_valid) begin
                        pair_done = 1'b1;
                        if (rise_valid) begin
                            rise_d   = rise_fine;
                            coarse_d = COARSE_BITS'(1);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (rise_valid) begin
                        rise_d   = rise_fine;
                        coarse_d = COARSE_BITS'(1);
                    end else if (coarse_q == COARSE_MAX) begin
                        timeout_ev = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Sample arithmetic; OFFSET >= 2^FINE_BITS-1 keeps the result non-negative.
    always_comb begin
        sample_vld_d = pair_done;
        sample_d     = sample_q;
        if (pair_done) begin
            sample_d = (SAMPLE_W'(coarse_q) << FINE_BITS) + SAMPLE_W'(OFFSET)
                     - SAMPLE_W'(fall_fine) + SAMPLE_W'(rise_q);
        end
    end

    // Block averager; the exponent is frozen when a block's first sample arrives.
    always_comb begin
        avg_clamped  = (avg_log2 > 3'(AVG_LOG2_MAX)) ? 3'(AVG_LOG2_MAX) : avg_log2;
        n_eff        = (cnt_q == '0) ? avg_clamped : n_q;
        acc_sum      = ((cnt_q == '0) ? '0 : acc_q) + ACC_W'(sample_q);
        cnt_inc      = cnt_q + 1'b1;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        n_d          = n_q;
        result_d     = result_q;
        result_vld_d = 1'b0;
        if (!enable) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (sample_vld_q) begin
            n_d = n_eff;
            if (cnt_inc == (CNT_W'(1) << n_eff)) begin
                result_d     = SAMPLE_W'(acc_sum >> n_eff);
                result_vld_d = 1'b1;
                acc_d        = '0;
                cnt_d        = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_inc;
            end
        end
    end

    // Sticky status: a set event in the clearing cycle keeps the bit set.
    always_comb begin
        overflow_ev = result_vld_q && fifo_full && !out_ready;
        status_d    = clear_status ? 3'b000 : status_q;
        if (stray_ev)    status_d[STAT_STRAY_FALL] = 1'b1;
        if (overflow_ev) status_d[STAT_OVERFLOW]   = 1'b1;
        if (timeout_ev)  status_d[STAT_TIMEOUT]    = 1'b1;
    end

    // State registers for pairing, sample, averaging and status.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rise_q       <= '0;
            coarse_q     <= '0;
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            n_q          <= '0;
            result_q     <= '0;
            result_vld_q <= 1'b0;
            status_q     <= '0;
        end else begin
            state_q      <= state_d;
            rise_q       <= rise_d;
            coarse_q     <= coarse_d;
            sample_q     <= sample_d;
            sample_vld_q <= sample_vld_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            n_q          <= n_d;
            result_q     <= result_d;
            result_vld_q <= result_vld_d;
            status_q     <= status_d;
        end
    end

    adcv_sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clock),
        .srst      (reset),
        .push      (result_vld_q),
        .push_data (result_q),
        .pop       (out_ready),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign out_valid = !fifo_empty;
    assign status    = status_q;

endmodule

// File: tb/tb_adcv_pair_accum.sv
// Directed bench for adcv_pair_accum with hand-computed expected results.
module tb_adcv_pair_accum;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [2:0]  avg_log2;
    logic        rise_valid;
    logic [5:0]  rise_fine;
    logic        fall_valid;
    logic [5:0]  fall_fine;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_data;
    logic [3:0]  fifo_level;
    logic        clear_status;
    logic [2:0]  status;

    int total = 0;
    int bad   = 0;

    adcv_pair_accum dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .avg_log2     (avg_log2),
        .rise_valid   (rise_valid),
        .rise_fine    (rise_fine),
        .fall_valid   (fall_valid),
        .fall_fine    (fall_fine),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .fifo_level   (fifo_level),
        .clear_status (clear_status),
        .status       (status)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Rise at the current cycle, fall gap cycles later; returns after the fall edge.
    task automatic pair(input logic [5:0] rf, input logic [5:0] ff, input int gap);
        rise_valid = 1'b1;
        rise_fine  = rf;
        tick();
        rise_valid = 1'b0;
        repeat (gap - 1) tick();
        fall_valid = 1'b1;
        fall_fine  = ff;
        tick();
        fall_valid = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_data"}, 32'(out_data), exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; avg_log2 = 3'd0;
        rise_valid = 1'b0; rise_fine = '0; fall_valid = 1'b0; fall_fine = '0;
        out_ready = 1'b0; clear_status = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_status", 32'(status), 0);
        reset = 1'b0;
        tick();

        // Single pair: 2*64+63-20+10 = 181, visible three cycles after the fall
        pair(6'd10, 6'd20, 2);
        chk("lat_f0", 32'(out_valid), 0);
        tick();
        chk("lat_f1", 32'(out_valid), 0);
        tick();
        pop_chk("single", 181);
        chk("single_drained", 32'(fifo_level), 0);

        // Averaging n=2: 100,101,102,103 -> 101; mid-block avg_log2 change ignored
        avg_log2 = 3'd2;
        pair(6'd0, 6'd27, 1);
        tick();
        avg_log2 = 3'd0;
        pair(6'd0, 6'd26, 1);
        pair(6'd0, 6'd25, 1);
        tick(); tick(); tick();
        chk("avg_partial_level", 32'(fifo_level), 0);
        pair(6'd0, 6'd24, 1);
        tick(); tick(); tick();
        chk("avg_level", 32'(fifo_level), 1);
        pop_chk("avg", 101);

        // Timeout: 16 cycles with no fall
        rise_valid = 1'b1; rise_fine = 6'd0;
        tick();
        rise_valid = 1'b0;
        repeat (15) tick();
        chk("timeout_status", 32'(status), 4);
        tick(); tick(); tick();
        chk("timeout_no_push", 32'(fifo_level), 0);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        chk("timeout_cleared", 32'(status), 0);
        // Fall exactly 15 cycles after rise is accepted: 15*64+63 = 1023
        pair(6'd0, 6'd0, 15);
        tick(); tick(); tick();
        chk("coarse15_status", 32'(status), 0);
        pop_chk("coarse15", 1023);

        // Stray fall in IDLE, then set-vs-clear collision
        fall_valid = 1'b1; fall_fine = 6'd5;
        tick();
        fall_valid = 1'b0;
        chk("stray_status", 32'(status), 1);
        fall_valid = 1'b1; clear_status = 1'b1;
        tick();
        fall_valid = 1'b0; clear_status = 1'b0;
        chk("stray_set_wins", 32'(status), 1);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        chk("stray_cleared", 32'(status), 0);

        // Back-to-back: rise 5, fall 20 + rise 8 two cycles later, fall 30 three later
        rise_valid = 1'b1; rise_fine = 6'd5;
        tick();
        rise_valid = 1'b0;
        tick();
        fall_valid = 1'b1; fall_fine = 6'd20; rise_valid = 1'b1; rise_fine = 6'd8;
        tick();
        fall_valid = 1'b0; rise_valid = 1'b0;
        tick(); tick();
        fall_valid = 1'b1; fall_fine = 6'd30;
        tick();
        fall_valid = 1'b0;
        tick(); tick(); tick();
        chk("b2b_level", 32'(fifo_level), 2);
        pop_chk("b2b_first", 176);
        pop_chk("b2b_second", 233);

        // Overflow: nine results 127..135 into a depth-8 FIFO
        for (int i = 0; i < 9; i++) pair(6'(i), 6'd0, 1);
        tick(); tick(); tick();
        chk("ovf_level", 32'(fifo_level), 8);
        chk("ovf_status", 32'(status), 2);
        chk("ovf_head", 32'(out_data), 127);
        // Push and pop together while full: level stays 8
        pair(6'd20, 6'd0, 1);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("full_pushpop_level", 32'(fifo_level), 8);
        for (int i = 1; i < 8; i++) pop_chk("ovf_order", 32'(127 + i));
        pop_chk("ovf_tail", 147);
        chk("ovf_drained", 32'(fifo_level), 0);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;

        // Enable drop discards a partial n=3 block of five 127s
        avg_log2 = 3'd3;
        for (int i = 0; i < 5; i++) pair(6'd0, 6'd0, 1);
        tick();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        for (int i = 0; i < 3; i++) pair(6'd0, 6'd27, 1);
        tick(); tick(); tick();
        chk("en_discard_level", 32'(fifo_level), 0);
        for (int i = 0; i < 5; i++) pair(6'd0, 6'd27, 1);
        tick(); tick(); tick();
        chk("en_block_level", 32'(fifo_level), 1);
        pop_chk("en_block", 100);

        // Reset with four results buffered and a sticky flag set
        avg_log2 = 3'd0;
        for (int i = 0; i < 4; i++) pair(6'd1, 6'd0, 1);
        tick(); tick(); tick();
        fall_valid = 1'b1;
        tick();
        fall_valid = 1'b0;
        chk("pre_reset_level", 32'(fifo_level), 4);
        chk("pre_reset_status", 32'(status), 1);
        reset = 1'b1;
        tick();
        chk("post_reset_level", 32'(fifo_level), 0);
        chk("post_reset_valid", 32'(out_valid), 0);
        chk("post_reset_data", 32'(out_data), 0);
        chk("post_reset_status", 32'(status), 0);
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
